// File: rtl/uart_tx_sched.sv
// uart_tx_sched
// Round-robin scheduler that shares one 11-bit-frame UART transmitter
// (start, 8 data bits LSB first, parity, stop) between NUM_REQ byte sources.
// It captures the winning byte and its parity, drives send/data/parity to the
// serializer, follows the serializer's active flag to detect the end of the
// frame, and pulses a per-requester done.
//
// Optional build macro: UART_TX_SCHED_WDOG_EN
//   When defined, a 5-bit watchdog aborts a transfer that stays in START for
//   more than 4 cycles or in XMIT for more than 14 cycles: it pulses err and
//   done[owner], drops tx_send and goes to GAP. When undefined, START/XMIT wait
//   indefinitely and err is constant 0.
module uart_tx_sched #(
  parameter int NUM_REQ    = 4,
  parameter int PARITY_ODD = 0,
  parameter int GAP_CYCLES = 1
) (
  input  logic                 baud_clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   done,
  output logic                 busy,
  output logic                 tx_send,
  output logic [7:0]           tx_data,
  output logic                 tx_parity,
  input  logic                 tx_active,
  input  logic                 tx_done,
  output logic                 err
);

  // Pointer width; at least one bit so NUM_REQ = 1 still elaborates.
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W:0]     NUM_REQ_W = (PTR_W+1)'(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE_HOT_0 = NUM_REQ'(32'd1);
  localparam logic               PAR_ODD   = (PARITY_ODD != 0);
  localparam logic [3:0]         GAP_LAST  = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_XMIT  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  // Where a finished or aborted frame goes next.
  localparam state_t POST_ST = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

  state_t               state_q, state_d;
  logic [PTR_W-1:0]     rr_q, rr_d;
  logic [PTR_W-1:0]     owner_q, owner_d;
  logic [3:0]           gap_cnt_q, gap_cnt_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 tx_send_q, tx_send_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_parity_q, tx_parity_d;

  logic                 grant_found_s;
  logic [PTR_W-1:0]     grant_idx_s;
  logic [PTR_W:0]       cand_sum_s;
  logic [PTR_W:0]       cand_s;
  logic                 hit_s;
  logic [7:0]           win_data_s;
  logic                 win_parity_s;
  logic [PTR_W:0]       rr_inc_s;
  logic [PTR_W-1:0]     rr_next_s;
  logic                 wdog_abort_s;

  // tx_done stays high after a frame, so sequencing relies on tx_active only.
  logic                 unused_tx_done_s;
  assign unused_tx_done_s = tx_done;

  // Parity of a captured byte: even = XOR of the bits, odd = its inverse.
  function automatic logic frame_parity(input logic [7:0] data, input logic odd);
    frame_parity = (^data) ^ odd;
  endfunction

  // Round-robin search: first requester at or after the rr pointer, with wrap
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    cand_sum_s    = '0;
    cand_s        = '0;
    hit_s         = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_sum_s    = {1'b0, rr_q} + (PTR_W+1)'(i);
      cand_s        = (cand_sum_s >= NUM_REQ_W) ? (cand_sum_s - NUM_REQ_W) : cand_sum_s;
      hit_s         = !grant_found_s && req[cand_s[PTR_W-1:0]];
      grant_idx_s   = hit_s ? cand_s[PTR_W-1:0] : grant_idx_s;
      grant_found_s = grant_found_s | hit_s;
    end
  end

  // Winner's byte, its parity and the pointer value just past the winner
  always_comb begin
    win_data_s   = req_data[{grant_idx_s, 3'b000} +: 8];
    win_parity_s = frame_parity(win_data_s, PAR_ODD);
    rr_inc_s     = {1'b0, grant_idx_s} + {{PTR_W{1'b0}}, 1'b1};
    if (rr_inc_s == NUM_REQ_W) begin
      rr_next_s = '0;
    end else begin
      rr_next_s = rr_inc_s[PTR_W-1:0];
    end
  end

`ifdef UART_TX_SCHED_WDOG_EN
  localparam logic [4:0] WDOG_START_LAST = 5'd4;
  localparam logic [4:0] WDOG_XMIT_LAST  = 5'd14;

  logic [4:0] wdog_cnt_q, wdog_cnt_d;
  logic       err_q, err_d;

  // Abort only when the normal exit condition has not arrived in time
  always_comb begin
    case (state_q)
      ST_START: wdog_abort_s = !tx_active && (wdog_cnt_q >= WDOG_START_LAST);
      ST_XMIT:  wdog_abort_s = tx_active && (wdog_cnt_q >= WDOG_XMIT_LAST);
      default:  wdog_abort_s = 1'b0;
    endcase
  end

  // Dwell counter for START/XMIT, cleared on every state change
  always_comb begin
    err_d = wdog_abort_s;
    if (state_d != state_q) begin
      wdog_cnt_d = 5'd0;
    end else if ((state_q == ST_START) || (state_q == ST_XMIT)) begin
      wdog_cnt_d = wdog_cnt_q + 5'd1;
    end else begin
      wdog_cnt_d = 5'd0;
    end
  end

  // Watchdog registers
  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_cnt_q <= 5'd0;
      err_q      <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      err_q      <= err_d;
    end
  end

  assign err = err_q;
`else
  assign wdog_abort_s = 1'b0;
  assign err          = 1'b0;
`endif

  // Scheduler FSM: next state and next values of all registered outputs
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    gap_cnt_d   = gap_cnt_q;
    tx_send_d   = tx_send_q;
    tx_data_d   = tx_data_q;
    tx_parity_d = tx_parity_q;
    ack_d       = '0;
    done_d      = '0;
    case (state_q)
      ST_IDLE: begin
        if (grant_found_s) begin
          owner_d     = grant_idx_s;
          rr_d        = rr_next_s;
          tx_data_d   = win_data_s;
          tx_parity_d = win_parity_s;
          ack_d       = ONE_HOT_0 << grant_idx_s;
          tx_send_d   = 1'b1;
          state_d     = ST_START;
        end else begin
          tx_send_d   = 1'b0;
        end
      end
      ST_START: begin
        // The serializer samples send only while idle, so holding it is safe.
        if (tx_active) begin
          tx_send_d = 1'b0;
          state_d   = ST_XMIT;
        end else if (wdog_abort_s) begin
          tx_send_d = 1'b0;
          done_d    = ONE_HOT_0 << owner_q;
          gap_cnt_d = 4'd0;
          state_d   = POST_ST;
        end else begin
          tx_send_d = 1'b1;
        end
      end
      ST_XMIT: begin
        if (!tx_active) begin
          done_d    = ONE_HOT_0 << owner_q;
          gap_cnt_d = 4'd0;
          state_d   = POST_ST;
        end else if (wdog_abort_s) begin
          tx_send_d = 1'b0;
          done_d    = ONE_HOT_0 << owner_q;
          gap_cnt_d = 4'd0;
          state_d   = POST_ST;
        end else begin
          state_d   = ST_XMIT;
        end
      end
      ST_GAP: begin
        // Requests are ignored here; they are looked at again in IDLE.
        if (gap_cnt_q >= GAP_LAST) begin
          gap_cnt_d = 4'd0;
          state_d   = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      default: begin
        tx_send_d = 1'b0;
        gap_cnt_d = 4'd0;
        state_d   = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State, pointer and output registers
  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      rr_q        <= '0;
      owner_q     <= '0;
      gap_cnt_q   <= 4'd0;
      ack_q       <= '0;
      done_q      <= '0;
      busy_q      <= 1'b0;
      tx_send_q   <= 1'b0;
      tx_data_q   <= 8'd0;
      tx_parity_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      owner_q     <= owner_d;
      gap_cnt_q   <= gap_cnt_d;
      ack_q       <= ack_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      tx_send_q   <= tx_send_d;
      tx_data_q   <= tx_data_d;
      tx_parity_q <= tx_parity_d;
    end
  end

  assign ack       = ack_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign tx_send   = tx_send_q;
  assign tx_data   = tx_data_q;
  assign tx_parity = tx_parity_q;

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler sharing one serial transmitter (PISO-style, 11-bit frame: start, 8 data LSB-first, parity, stop) between NUM_REQ byte sources.
- Captures a winner's byte, computes parity, drives the transmitter's send/data/parity inputs, tracks frame completion, and reports per-requester completion.
- Runs in the baud clock domain alongside the transmitter; sits between the UART TX FIFOs/host registers and the serializer.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- PARITY_ODD, 0, 0 = even parity (XOR of data), 1 = odd parity (inverted XOR).
- GAP_CYCLES, 1, idle baud cycles forced between frames (0..15).

Ports:
- baud_clk  in  1  baud-rate clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester level request; data must be valid while high.
- req_data  in  8*NUM_REQ  byte for requester i in bits [8i+7:8i].
- ack  out  NUM_REQ  one-hot, one-cycle pulse: byte captured, requester may change data/drop req.
- done  out  NUM_REQ  one-hot, one-cycle pulse: that requester's frame finished.
- busy  out  1  high in any state other than IDLE.
- tx_send  out  1  to transmitter send.
- tx_data  out  8  to transmitter data_in; held stable for the whole frame.
- tx_parity  out  1  to transmitter parity_bit; held stable for the whole frame.
- tx_active  in  1  transmitter active_flag.
- tx_done  in  1  transmitter done_flag (sticky level, informational only).
- err  out  1  one-cycle pulse on watchdog abort (TX_WDOG_EN only; tied 0 otherwise).

Behaviour:
- Reset values (async): state IDLE; ack, done, tx_send, busy, err = 0; tx_data = 0; tx_parity = 0; rr pointer = 0; owner = 0; gap counter = 0.
- States: IDLE, START, XMIT, GAP.
- IDLE:
  - If any req, pick the first set bit searching from rr pointer upward with wrap.
  - Same edge: latch tx_data, tx_parity = ^data ^ PARITY_ODD, and owner. Pulse ack[owner], set tx_send = 1, go to START.
  - rr pointer = owner+1 modulo NUM_REQ.
- START:
  - Hold tx_send = 1 until tx_active = 1 is sampled, then clear tx_send and go to XMIT.
  - The transmitter only samples send in its idle state, so holding send is safe.
  - Expected dwell: 2 cycles.
- XMIT:
  - Wait for tx_active = 0, then pulse done[owner].
  - Go to GAP if GAP_CYCLES > 0, else IDLE.
  - tx_done is not used for sequencing because it stays high after the frame.
- GAP:
  - Count GAP_CYCLES cycles, then go to IDLE.
  - New requests are ignored until back in IDLE.
- Latency: req sampled high → ack on next edge; first tx_active 2 edges after ack; done 1 cycle after tx_active falls. A frame occupies 11 active cycles.
- Fairness: with all requesters continuously requesting, grant order is 0,1,2,3,0…; no requester waits more than NUM_REQ-1 frames.
- A req dropped before ack is simply not served. tx_data/tx_parity change only at capture.
- ack and done for different requesters never coincide: done is in XMIT, ack only from IDLE.
- Reset mid-frame returns to IDLE immediately with tx_send = 0. No done is issued; the owner must re-request.
- NUM_REQ = 1 degenerates to a pass-through with gap insertion.

Optional Feature:
- Macro UART_TX_SCHED_WDOG_EN. When defined, adds a 5-bit watchdog counter.
  - START lasting more than 4 cycles, or XMIT lasting more than 14 cycles, aborts the transfer: tx_send = 0, pulse err, pulse done[owner], go to GAP.
  - Counter clears on every state change.
- When not defined: no counter; START/XMIT wait indefinitely; err is constant 0.

Test Plan:
- Single request: req=0001, req_data[7:0]=8'hA5, PARITY_ODD=0 → ack=0001 one cycle, tx_data=A5, tx_parity=0, tx_send high 2 cycles, serial line = 0,1,0,1,0,0,1,0,1,0,1, done=0001 once, busy low after 1 gap cycle.
- Odd parity: PARITY_ODD=1, byte 8'h07 → tx_parity=0; byte 8'h03 → tx_parity=1.
- Round robin: req=1111 held with bytes 11,22,33,44 → frames in order 11,22,33,44,11; acks rotate 0001,0010,0100,1000,0001.
- Data stability: change req_data[7:0] from 5A to FF one cycle after ack → transmitted frame still carries 5A; tx_data constant across all 11 active cycles.
- Reset mid-frame: assert reset_n=0 at the 5th tx_active cycle → tx_send=0, busy=0, no done pulse; after release, req=0001 is re-served from IDLE with rr pointer 0.
- Watchdog (UART_TX_SCHED_WDOG_EN): hold tx_active=0 after capture → err pulse and done[owner] in the 5th START cycle, tx_send low; the next request is served normally after the gap.
